// File: rtl/spi_target_rx.sv
`timescale 1ns / 1ps
// spi_target_rx
//   SPI mode-0 target (CPOL=0, CPHA=0), MSB first, oversampled by clk.
//   SCK, COPI and CS are brought into the clk domain through SYNC_STAGES
//   flops and edges are detected on the synchronized SCK.
//   Received bytes are presented on rx_byte_o with a one-cycle rx_valid_o.
//   Bytes to transmit are staged in a one-deep holding register.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-low
//   spi_sck_i    SPI clock (asynchronous to clk)
//   spi_copi_i   SPI data in, MSB first
//   spi_cs_i     target select, active-low
//   spi_cipo_o   SPI data out, MSB first
//   rx_byte_o    last complete received byte
//   rx_valid_o   one-cycle strobe, rx_byte_o is new
//   rx_first_o   with rx_valid_o: byte is the first of the transaction
//   rx_end_o     one-cycle strobe on transaction end
//   rx_abort_o   one-cycle strobe, transaction ended mid-byte
//   tx_byte_i    next byte to send
//   tx_load_i    write tx_byte_i into the holding register
//   tx_empty_o   holding register is empty
module spi_target_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_sck_i,
   input  logic       spi_copi_i,
   input  logic       spi_cs_i,
   output logic       spi_cipo_o,
   output logic [7:0] rx_byte_o,
   output logic       rx_valid_o,
   output logic       rx_first_o,
   output logic       rx_end_o,
   output logic       rx_abort_o,
   input  logic [7:0] tx_byte_i,
   input  logic       tx_load_i,
   output logic       tx_empty_o
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t state_reg, state_next;

   logic [SYNC_STAGES-1:0] sck_sync_reg, copi_sync_reg, cs_sync_reg, vld_sync_reg;
   logic       sck_s, copi_s, cs_s, sync_ok;
   logic       sck_q_reg;
   logic       armed_reg;
   logic [2:0] bit_cnt_reg, bit_cnt_inc, bit_cnt_after;
   logic       first_reg;
   logic [7:0] rx_shift_reg;
   logic       byte_done_reg, byte_first_reg;
   logic       end_pend_reg, abort_pend_reg;
   logic [7:0] rx_byte_reg;
   logic       rx_valid_reg, rx_first_reg, rx_end_reg, rx_abort_reg;
   logic [7:0] tx_shift_reg, hold_reg;
   logic       hold_full_reg;
   logic       enter_active, leave_active;
   logic       rise, fall, byte_complete, reload;

   // Synchronizers. vld_sync_reg marks when the chain holds real pin samples
   // rather than reset values, so a CS held low through reset is not mistaken
   // for a fresh falling edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sck_sync_reg  <= '0;
         copi_sync_reg <= '0;
         cs_sync_reg   <= '1;
         vld_sync_reg  <= '0;
      end else begin
         sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], spi_sck_i};
         copi_sync_reg <= {copi_sync_reg[SYNC_STAGES-2:0], spi_copi_i};
         cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_i};
         vld_sync_reg  <= {vld_sync_reg[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sck_s   = sck_sync_reg[SYNC_STAGES-1];
   assign copi_s  = copi_sync_reg[SYNC_STAGES-1];
   assign cs_s    = cs_sync_reg[SYNC_STAGES-1];
   assign sync_ok = vld_sync_reg[SYNC_STAGES-1];

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // FSM next state: entry needs CS seen high (armed) and now low
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (armed_reg && sync_ok && !cs_s) state_next = ACTIVE;
         ACTIVE:  if (cs_s) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      enter_active = 1'b0;
      leave_active = 1'b0;
      if (state_reg == IDLE && state_next == ACTIVE) enter_active = 1'b1;
      if (state_reg == ACTIVE && state_next == IDLE) leave_active = 1'b1;
   end

   // Edges count while the FSM is ACTIVE, including the cycle in which CS is
   // seen rising, so a final SCK rise coincident with CS release still
   // completes its byte.
   assign rise          = (state_reg == ACTIVE) && sck_s && !sck_q_reg;
   assign fall          = (state_reg == ACTIVE) && !sck_s && sck_q_reg;
   assign bit_cnt_inc   = bit_cnt_reg + 3'd1;
   assign bit_cnt_after = rise ? bit_cnt_inc : bit_cnt_reg;
   assign byte_complete = rise && (bit_cnt_reg == 3'd7);
   assign reload        = enter_active || (fall && (bit_cnt_reg == 3'd0));

   always_ff @(posedge clk) begin
      if (!reset) begin
         sck_q_reg      <= 1'b0;
         armed_reg      <= 1'b0;
         bit_cnt_reg    <= 3'd0;
         first_reg      <= 1'b0;
         rx_shift_reg   <= 8'h00;
         byte_done_reg  <= 1'b0;
         byte_first_reg <= 1'b0;
         end_pend_reg   <= 1'b0;
         abort_pend_reg <= 1'b0;
         rx_byte_reg    <= 8'h00;
         rx_valid_reg   <= 1'b0;
         rx_first_reg   <= 1'b0;
         rx_end_reg     <= 1'b0;
         rx_abort_reg   <= 1'b0;
         tx_shift_reg   <= 8'hFF;
         hold_reg       <= 8'h00;
         hold_full_reg  <= 1'b0;
      end else begin
         sck_q_reg <= sck_s;
         if (sync_ok && cs_s) armed_reg <= 1'b1;

         if (enter_active) begin
            bit_cnt_reg <= 3'd0;
            first_reg   <= 1'b1;
         end else if (rise) begin
            bit_cnt_reg  <= bit_cnt_inc;
            rx_shift_reg <= {rx_shift_reg[6:0], copi_s};
            if (byte_complete) first_reg <= 1'b0;
         end

         // One pipeline stage between the edge and the strobes; the end
         // strobes share it so a coincident byte and CS release line up.
         byte_done_reg  <= byte_complete;
         byte_first_reg <= byte_complete && first_reg;
         end_pend_reg   <= leave_active;
         abort_pend_reg <= leave_active && (bit_cnt_after != 3'd0);

         rx_valid_reg <= byte_done_reg;
         rx_first_reg <= byte_first_reg;
         rx_end_reg   <= end_pend_reg;
         rx_abort_reg <= abort_pend_reg;
         if (byte_done_reg) rx_byte_reg <= rx_shift_reg;

         if (reload)    tx_shift_reg <= hold_full_reg ? hold_reg : 8'hFF;
         else if (fall) tx_shift_reg <= {tx_shift_reg[6:0], 1'b1};

         // A load wins over the reload's clear: the reload has already taken
         // the old value, and the new one stays held.
         if (tx_load_i) begin
            hold_reg      <= tx_byte_i;
            hold_full_reg <= 1'b1;
         end else if (reload && hold_full_reg) begin
            hold_full_reg <= 1'b0;
         end
      end
   end

   assign spi_cipo_o = tx_shift_reg[7];
   assign rx_byte_o  = rx_byte_reg;
   assign rx_valid_o = rx_valid_reg;
   assign rx_first_o = rx_first_reg;
   assign rx_end_o   = rx_end_reg;
   assign rx_abort_o = rx_abort_reg;
   assign tx_empty_o = !hold_full_reg;

endmodule

// File: tb/tb_spi_target_rx.sv
`timescale 1ns / 1ps
// Directed bench for spi_target_rx: SCK at clk/8, strobes captured by a
// negedge monitor, every comparison an immediate assertion.
module tb_spi_target_rx;

   localparam int SYNC_STAGES = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       spi_sck_i, spi_copi_i, spi_cs_i, spi_cipo_o;
   logic [7:0] rx_byte_o;
   logic       rx_valid_o, rx_first_o, rx_end_o, rx_abort_o;
   logic [7:0] tx_byte_i;
   logic       tx_load_i, tx_empty_o;

   always #5 clk = ~clk;

   spi_target_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk        (clk),
      .reset      (reset),
      .spi_sck_i  (spi_sck_i),
      .spi_copi_i (spi_copi_i),
      .spi_cs_i   (spi_cs_i),
      .spi_cipo_o (spi_cipo_o),
      .rx_byte_o  (rx_byte_o),
      .rx_valid_o (rx_valid_o),
      .rx_first_o (rx_first_o),
      .rx_end_o   (rx_end_o),
      .rx_abort_o (rx_abort_o),
      .tx_byte_i  (tx_byte_i),
      .tx_load_i  (tx_load_i),
      .tx_empty_o (tx_empty_o)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor
   logic [7:0] vbyte_q[$];
   logic       vfirst_q[$];
   int         vcyc_q[$];
   int         end_cnt = 0, abort_cnt = 0, end_cyc = -1, abort_cyc = -1;

   always @(negedge clk) begin
      if (rx_valid_o) begin
         vbyte_q.push_back(rx_byte_o);
         vfirst_q.push_back(rx_first_o);
         vcyc_q.push_back(cyc);
      end
      if (rx_end_o) begin
         end_cnt++;
         end_cyc = cyc;
      end
      if (rx_abort_o) begin
         abort_cnt++;
         abort_cyc = cyc;
      end
   end

   int n_vec = 0, n_err = 0;
   int last_e0 = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Shift nbits out MSB first; cipo is sampled just before each rise.
   // With inj set, tx_load_i pulses in the cycle the last fall is acted on.
   task automatic xfer(input logic [7:0] mosi, input int nbits, input bit inj,
                       input logic [7:0] inj_val, output logic [7:0] miso);
      miso = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         miso       = {miso[6:0], spi_cipo_o};
         spi_copi_i = mosi[7-i];
         spi_sck_i  = 1'b1;
         last_e0    = cyc + 1;
         wait_n(4);
         spi_sck_i = 1'b0;
         for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (inj && i == nbits - 1) begin
               if (j == 2) begin
                  tx_byte_i = inj_val;
                  tx_load_i = 1'b1;
               end
               if (j == 3) tx_load_i = 1'b0;
            end
         end
      end
   endtask

   task automatic check_valid(input string tag, input logic [7:0] eb, input logic ef,
                              input bit chk_lat, output int vc);
      logic [7:0] b;
      logic       f;
      vc = -1;
      check({tag, "_present"}, (vbyte_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (vbyte_q.size() != 0) begin
         b  = vbyte_q.pop_front();
         f  = vfirst_q.pop_front();
         vc = vcyc_q.pop_front();
         check({tag, "_byte"}, 32'(b), 32'(eb));
         check({tag, "_first"}, 32'(f), 32'(ef));
         if (chk_lat) check({tag, "_latency"}, 32'(vc - last_e0), 32'(SYNC_STAGES + 1));
      end
   endtask

   task automatic load_tx(input logic [7:0] v);
      tx_byte_i = v;
      tx_load_i = 1'b1;
      @(negedge clk);
      tx_load_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cipo"}, 32'(spi_cipo_o), 32'd1);
      check({tag, "_tx_empty"}, 32'(tx_empty_o), 32'd1);
      check({tag, "_rx_byte"}, 32'(rx_byte_o), 32'h00);
      check({tag, "_valid"}, 32'(rx_valid_o), 32'd0);
      check({tag, "_first"}, 32'(rx_first_o), 32'd0);
      check({tag, "_end"}, 32'(rx_end_o), 32'd0);
      check({tag, "_abort"}, 32'(rx_abort_o), 32'd0);
   endtask

   initial begin
      logic [7:0] miso;
      int         vc;

      reset      = 1'b0;
      spi_cs_i   = 1'b1;
      spi_sck_i  = 1'b0;
      spi_copi_i = 1'b0;
      tx_byte_i  = 8'h00;
      tx_load_i  = 1'b0;
      wait_n(4);
      check_reset_outputs("rst");
      reset = 1'b1;
      wait_n(6);

      // Single byte A5 with latency check
      spi_cs_i = 1'b0; wait_n(6);
      xfer(8'hA5, 8, 1'b0, 8'h00, miso);
      wait_n(4);
      check_valid("a5", 8'hA5, 1'b1, 1'b1, vc);
      check("a5_cipo", 32'(miso), 32'hFF);
      spi_cs_i = 1'b1; wait_n(8);
      check("a5_end_cnt", 32'(end_cnt), 32'd1);
      check("a5_abort_cnt", 32'(abort_cnt), 32'd0);
      check("a5_extra_valid", 32'(vbyte_q.size()), 32'd0);

      // Preloaded 3C, two bytes
      load_tx(8'h3C);
      check("ld_empty", 32'(tx_empty_o), 32'd0);
      check("ld_cipo_idle", 32'(spi_cipo_o), 32'd1);
      spi_cs_i = 1'b0; wait_n(6);
      check("ld_empty_after_cs", 32'(tx_empty_o), 32'd1);
      check("ld_cipo_msb", 32'(spi_cipo_o), 32'd0);
      xfer(8'h01, 8, 1'b0, 8'h00, miso);
      check("two_cipo0", 32'(miso), 32'h3C);
      xfer(8'h02, 8, 1'b0, 8'h00, miso);
      check("two_cipo1", 32'(miso), 32'hFF);
      wait_n(2);
      check_valid("two_b0", 8'h01, 1'b1, 1'b0, vc);
      check_valid("two_b1", 8'h02, 1'b0, 1'b1, vc);
      spi_cs_i = 1'b1; wait_n(8);
      check("two_end_cnt", 32'(end_cnt), 32'd2);
      check("two_abort_cnt", 32'(abort_cnt), 32'd0);
      check("two_tx_empty", 32'(tx_empty_o), 32'd1);

      // Abort after 5 bits, then a fresh byte is first again
      spi_cs_i = 1'b0; wait_n(6);
      xfer(8'hE0, 5, 1'b0, 8'h00, miso);
      spi_cs_i = 1'b1; wait_n(8);
      check("abt_end_cnt", 32'(end_cnt), 32'd3);
      check("abt_abort_cnt", 32'(abort_cnt), 32'd1);
      check("abt_same_cycle", 32'(end_cyc), 32'(abort_cyc));
      check("abt_no_valid", 32'(vbyte_q.size()), 32'd0);
      spi_cs_i = 1'b0; wait_n(6);
      xfer(8'h5A, 8, 1'b0, 8'h00, miso);
      wait_n(2);
      check_valid("abt_next", 8'h5A, 1'b1, 1'b1, vc);
      spi_cs_i = 1'b1; wait_n(8);
      check("abt_next_end", 32'(end_cnt), 32'd4);

      // Last rise coincident with CS release: valid and end together, no abort
      spi_cs_i = 1'b0; wait_n(6);
      xfer(8'h96, 7, 1'b0, 8'h00, miso);
      spi_copi_i = 1'b0;
      spi_sck_i  = 1'b1;
      spi_cs_i   = 1'b1;
      last_e0    = cyc + 1;
      wait_n(4);
      spi_sck_i = 1'b0;
      wait_n(8);
      check_valid("coin", 8'h96, 1'b1, 1'b1, vc);
      check("coin_end_cnt", 32'(end_cnt), 32'd5);
      check("coin_abort_cnt", 32'(abort_cnt), 32'd1);
      check("coin_end_cycle", 32'(end_cyc), 32'(vc));

      // Load coincident with byte-boundary reload
      spi_cs_i = 1'b0; wait_n(6);
      load_tx(8'h11);
      check("rl_empty0", 32'(tx_empty_o), 32'd0);
      xfer(8'h77, 8, 1'b1, 8'h22, miso);
      check("rl_cipo0", 32'(miso), 32'hFF);
      check("rl_held", 32'(tx_empty_o), 32'd0);
      xfer(8'h33, 8, 1'b0, 8'h00, miso);
      check("rl_cipo1", 32'(miso), 32'h11);
      xfer(8'h44, 8, 1'b0, 8'h00, miso);
      check("rl_cipo2", 32'(miso), 32'h22);
      check("rl_empty_end", 32'(tx_empty_o), 32'd1);
      spi_cs_i = 1'b1; wait_n(8);
      check_valid("rl_b0", 8'h77, 1'b1, 1'b0, vc);
      check_valid("rl_b1", 8'h33, 1'b0, 1'b0, vc);
      check_valid("rl_b2", 8'h44, 1'b0, 1'b0, vc);
      check("rl_end_cnt", 32'(end_cnt), 32'd6);

      // Reset mid-transaction, CS held low across it
      spi_cs_i = 1'b0; wait_n(6);
      xfer(8'hF0, 4, 1'b0, 8'h00, miso);
      reset = 1'b0;
      wait_n(3);
      check_reset_outputs("mrst");
      reset = 1'b1;
      wait_n(10);
      xfer(8'hFF, 8, 1'b0, 8'h00, miso);
      wait_n(4);
      check("mrst_no_valid", 32'(vbyte_q.size()), 32'd0);
      check("mrst_cipo", 32'(spi_cipo_o), 32'd1);
      spi_cs_i = 1'b1; wait_n(8);
      check("mrst_end_cnt", 32'(end_cnt), 32'd6);
      check("mrst_abort_cnt", 32'(abort_cnt), 32'd1);
      spi_cs_i = 1'b0; wait_n(6);
      xfer(8'hC3, 8, 1'b0, 8'h00, miso);
      wait_n(4);
      check_valid("mrst_next", 8'hC3, 1'b1, 1'b1, vc);
      spi_cs_i = 1'b1; wait_n(8);
      check("mrst_next_end", 32'(end_cnt), 32'd7);
      check("mrst_next_abort", 32'(abort_cnt), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_target_rx.md
SPI_TARGET_RX -- requirements
Module: spi_target_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on spi_sck_i, spi_copi_i and spi_cs_i (legal values 2..3).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-004 SHALL have port spi_sck_i, input, 1 bit: SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-005 SHALL have port spi_copi_i, input, 1 bit: data from the initiator, MSB first.
REQ-006 SHALL have port spi_cs_i, input, 1 bit: target select, active-low.
REQ-007 SHALL have port spi_cipo_o, output, 1 bit: data to the initiator, MSB first.
REQ-008 SHALL have port rx_byte_o, output, 8 bits: last complete received byte.
REQ-009 SHALL have port rx_valid_o, output, 1 bit: one-cycle strobe, rx_byte_o is new.
REQ-010 SHALL have port rx_first_o, output, 1 bit: qualifies rx_valid_o; the byte is the first of the transaction.
REQ-011 SHALL have port rx_end_o, output, 1 bit: one-cycle strobe on transaction end (cs deassert).
REQ-012 SHALL have port rx_abort_o, output, 1 bit: one-cycle strobe; the transaction ended mid-byte.
REQ-013 SHALL have port tx_byte_i, input, 8 bits: next byte to send.
REQ-014 SHALL have port tx_load_i, input, 1 bit: write tx_byte_i into the holding register.
REQ-015 SHALL have port tx_empty_o, output, 1 bit: holding register is empty.

Function
REQ-016 SHALL pass each SPI input through SYNC_STAGES flops; sck_s, copi_s and cs_s denote the last stage, and sck_q is sck_s delayed one more cycle.
REQ-017 SHALL detect a rise when sck_s & ~sck_q, and a fall when ~sck_s & sck_q; edges SHALL be ignored while cs_s=1.
REQ-018 SHALL implement a two-state FSM: IDLE (cs_s=1) and ACTIVE (cs_s=0), with IDLE->ACTIVE on cs_s falling and ACTIVE->IDLE on cs_s rising.
REQ-019 On IDLE->ACTIVE, SHALL clear the 3-bit bit counter, set the first-byte flag and load the tx shifter from the holding register if full (then mark it empty), else with 8'hFF.
REQ-020 On a rise in ACTIVE, SHALL shift copi_s into the rx shifter LSB and increment the bit counter modulo 8.
REQ-021 On the rise that completes bit 8 (counter 7->0), SHALL register the byte so that rx_byte_o updates and rx_valid_o=1 exactly SYNC_STAGES+1 clk cycles after the first clk edge sampling spi_sck_i high.
REQ-022 On that same byte-completing rise, SHALL drive rx_first_o to the first-byte flag and then clear the flag.
REQ-023 On a fall in ACTIVE, SHALL shift the tx shifter left by one.
REQ-024 On a fall in ACTIVE with the bit counter at 0 (byte boundary), SHALL instead reload the tx shifter from the holding register if full (then mark it empty), else with 8'hFF.
REQ-025 SHALL drive spi_cipo_o from tx shifter bit 7 in every state.
REQ-026 tx_load_i SHALL fill the holding register and clear tx_empty_o on the next cycle; a load into a full holding register SHALL overwrite it.
REQ-027 When tx_load_i coincides with a holding-register reload, the reload SHALL take the old value and the new value SHALL remain held with tx_empty_o=0.
REQ-028 On ACTIVE->IDLE, SHALL pulse rx_end_o for one cycle and pulse rx_abort_o in the same cycle if the bit counter is not 0.
REQ-029 On ACTIVE->IDLE, SHALL discard the partial byte without asserting rx_valid_o.
REQ-030 If a byte completes and cs_s rises in the same cycle, rx_valid_o and rx_end_o SHALL both pulse with rx_abort_o=0.
REQ-031 rx_valid_o, rx_end_o and rx_abort_o SHALL each be high for exactly one cycle per event.
REQ-032 Correct operation SHALL require each spi_sck_i half-period to be at least 2 clk periods.

Reset
REQ-033 While reset=0 at a clk edge, SHALL clear all synchronizer flops to sck=0, copi=0, cs=1.
REQ-034 While reset=0 at a clk edge, SHALL set the FSM to IDLE, clear the bit counter and the first-byte flag, and set rx_byte_o=8'h00.
REQ-035 While reset=0 at a clk edge, SHALL force rx_valid_o, rx_first_o, rx_end_o and rx_abort_o to 0, set the tx shifter to 8'hFF so that spi_cipo_o=1, and set tx_empty_o=1.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction with no strobes; the FSM SHALL re-enter ACTIVE only after cs_s is seen at 1 and then falls.

Verification
REQ-037 Reset, then cs low and send 8'hA5 with sck = clk/8 -> one rx_valid_o with rx_byte_o=8'hA5, rx_first_o=1, at latency SYNC_STAGES+1 from the 8th sck rise.
REQ-038 Load tx 8'h3C before cs low, then transfer two bytes 8'h01, 8'h02 -> cipo sends 8'h3C then 8'hFF; rx bytes 8'h01 (first=1) then 8'h02 (first=0); rx_end_o pulses once; tx_empty_o returns to 1.
REQ-039 Raise cs after 5 bits -> rx_end_o=1 and rx_abort_o=1 in the same cycle; no rx_valid_o; the next transaction's byte has rx_first_o=1.
REQ-040 Pulse tx_load_i in the same cycle as a byte-boundary reload, with holding register 8'h11 and load value 8'h22 -> 8'h11 is shifted out and 8'h22 is held with tx_empty_o=0.
REQ-041 Assert reset after 4 bits of a transaction -> no strobes, all outputs at reset values; the following full transaction receives its byte correctly.
